// File: rtl/gray_step_pkg.sv
// Shared types and helpers for the Gray step sequencer and its backlog counter.
package gray_step_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUpHi,
    StDnHi,
    StRstHi,
    StGapLo
  } state_e;

  localparam int unsigned PendWDefault = 4;
  localparam int PEND_MAX = (1 << (PendWDefault - 1)) - 1;
  localparam int PEND_MIN = -(1 << (PendWDefault - 1));

  function automatic int pend_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int pend_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Signed saturating backlog accumulator with a sticky overflow flag.
module sat_updown_counter
  import gray_step_pkg::*;
#(
  parameter int unsigned Width  = PendWDefault,
  parameter int          MaxVal = PEND_MAX,
  parameter int          MinVal = PEND_MIN
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  input  logic                    consume_up_i,
  input  logic                    consume_dn_i,
  input  logic                    clear_i,
  output logic signed [Width-1:0] count_o,
  output logic                    overflow_o
);

  logic signed [Width-1:0] count_d, count_q;
  logic                    ovf_d, ovf_q;
  int                      sum;

  // All contributions are combined before clamping, so opposing terms cancel first.
  always_comb begin
    sum = int'(count_q) + int'(inc_i) - int'(dec_i) - int'(consume_up_i) + int'(consume_dn_i);
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (sum > MaxVal) begin
      count_d = Width'(MaxVal);
      ovf_d   = 1'b1;
    end else if (sum < MinVal) begin
      count_d = Width'(MinVal);
      ovf_d   = 1'b1;
    end else begin
      count_d = Width'(sum);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/gray_step_sequencer.sv
// Drives a pulse-clocked Gray up/down counter from a saturating step backlog,
// with fixed pulse high/low widths and a shadow of the counter's Gray code.
module gray_step_sequencer
  import gray_step_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned HI_CYCLES = 2,
  parameter int unsigned LO_CYCLES = 2,
  parameter int unsigned PEND_W    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     up_req,
  input  logic                     down_req,
  input  logic                     clr_req,
  input  logic                     run,
  output logic                     step_up,
  output logic                     step_down,
  output logic                     cnt_reset,
  output logic                     busy,
  output logic signed [PEND_W-1:0] pending,
  output logic [WIDTH-1:0]         shadow_code,
  output logic                     overflow
);

  localparam int unsigned MaxCyc = (HI_CYCLES > LO_CYCLES) ? HI_CYCLES : LO_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  state_e           state_d, state_q, go;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic [WIDTH-1:0] bin_d, bin_q, shadow_d, shadow_q;
  logic             clr_pend_d, clr_pend_q;
  logic             step_up_q, step_down_q, cnt_reset_q, busy_q;
  logic             decide, enter_up, enter_dn, enter_rst;

  sat_updown_counter #(
    .Width  (PEND_W),
    .MaxVal (pend_max(PEND_W)),
    .MinVal (pend_min(PEND_W))
  ) u_backlog (
    .clk_i        (clk),
    .reset_i      (reset),
    .inc_i        (up_req),
    .dec_i        (down_req),
    .consume_up_i (enter_up),
    .consume_dn_i (enter_dn),
    .clear_i      (enter_rst),
    .count_o      (pending),
    .overflow_o   (overflow)
  );

  always_comb begin
    go = StIdle;
    if (clr_pend_q)               go = StRstHi;
    else if (run && pending > 0)  go = StUpHi;
    else if (run && pending < 0)  go = StDnHi;

    // The last gap cycle makes the idle decision so steps repeat every HI+LO cycles.
    decide = (state_q == StIdle) || (state_q == StGapLo && cnt_q == '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (decide) begin
      state_d = go;
      cnt_d   = CntW'(HI_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      state_d = StGapLo;
      cnt_d   = CntW'(LO_CYCLES - 1);
    end

    enter_up  = decide && (go == StUpHi);
    enter_dn  = decide && (go == StDnHi);
    enter_rst = decide && (go == StRstHi);

    bin_d = bin_q;
    if (enter_up)       bin_d = bin_q + WIDTH'(1);
    else if (enter_dn)  bin_d = bin_q - WIDTH'(1);
    else if (enter_rst) bin_d = '0;

    clr_pend_d = enter_rst ? 1'b0 : (clr_pend_q | clr_req);
    shadow_d   = WIDTH'(bin2gray(32'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bin_q       <= '0;
      shadow_q    <= '0;
      clr_pend_q  <= 1'b0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      cnt_reset_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      shadow_q    <= shadow_d;
      clr_pend_q  <= clr_pend_d;
      step_up_q   <= (state_d == StUpHi);
      step_down_q <= (state_d == StDnHi);
      cnt_reset_q <= (state_d == StRstHi);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign step_up     = step_up_q;
  assign step_down   = step_down_q;
  assign cnt_reset   = cnt_reset_q;
  assign busy        = busy_q;
  assign shadow_code = shadow_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Randomised and directed bench for gray_step_sequencer with a queue-based scoreboard.
module tb_gray_step_sequencer;

  localparam int HI = 2;
  localparam int LO = 2;

  logic              clk;
  logic              reset, up_req, down_req, clr_req, run;
  logic              step_up, step_down, cnt_reset, busy, overflow;
  logic signed [3:0] pending;
  logic [2:0]        shadow_code;

  gray_step_sequencer #(
    .WIDTH     (3),
    .HI_CYCLES (HI),
    .LO_CYCLES (LO),
    .PEND_W    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .up_req      (up_req),
    .down_req    (down_req),
    .clr_req     (clr_req),
    .run         (run),
    .step_up     (step_up),
    .step_down   (step_down),
    .cnt_reset   (cnt_reset),
    .busy        (busy),
    .pending     (pending),
    .shadow_code (shadow_code),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  string       phase = "reset";
  int          up_rises = 0;
  logic        prev_up = 1'b0;

  // Reference: backlog as an integer, pulses as HI+LO-cycle windows starting at t=0.
  int m_pend, m_ovf, m_clrp, m_bin, m_kind, m_t;

  task automatic model_step(input bit u, input bit d, input bit c, input bit r, input bit rs);
    int nk;
    int delta;
    int g;
    bit decide;
    logic [11:0] e;
    if (rs) begin
      m_pend = 0; m_ovf = 0; m_clrp = 0; m_bin = 0; m_kind = 0; m_t = 0;
    end else begin
      decide = (m_kind == 0) || (m_t == HI + LO - 1);
      nk = 0;
      if (decide) begin
        if (m_clrp != 0)          nk = 3;
        else if (r && m_pend > 0) nk = 1;
        else if (r && m_pend < 0) nk = 2;
      end
      if (nk == 3) begin
        m_pend = 0; m_ovf = 0; m_clrp = 0; m_bin = 0;
      end else begin
        delta = int'(u) - int'(d);
        if (nk == 1) begin delta = delta - 1; m_bin = (m_bin + 1) % 8; end
        if (nk == 2) begin delta = delta + 1; m_bin = (m_bin + 7) % 8; end
        m_pend = m_pend + delta;
        if (m_pend > 7)  begin m_pend = 7;  m_ovf = 1; end
        if (m_pend < -8) begin m_pend = -8; m_ovf = 1; end
        if (c) m_clrp = 1;
      end
      if (decide) begin m_kind = nk; m_t = 0; end
      else m_t = m_t + 1;
    end
    g = m_bin ^ (m_bin >> 1);
    e = {(m_kind == 1 && m_t < HI), (m_kind == 2 && m_t < HI), (m_kind == 3 && m_t < HI),
         (m_kind != 0), 4'(m_pend), 3'(g), (m_ovf != 0)};
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit u, input bit d, input bit c, input bit r, input bit rs);
    up_req = u; down_req = d; clr_req = c; run = r; reset = rs;
    @(posedge clk);
    model_step(u, d, c, r, rs);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [11:0] act, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {step_up, step_down, cnt_reset, busy, pending, shadow_code, overflow};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s @%0t: {up,dn,rst,busy,pend,shadow,ovf} got %b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b",
                 phase, $time, act[11], act[10], act[9], act[8], act[7:4], act[3:1], act[0],
                 exp[11], exp[10], exp[9], exp[8], exp[7:4], exp[3:1], exp[0]);
      end
    end
    if (step_up === 1'b1 && prev_up !== 1'b1) up_rises++;
    prev_up = step_up;
  end

  initial begin
    up_req = 0; down_req = 0; clr_req = 0; run = 0; reset = 1;

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    idle(2, 1);

    phase = "three_up";
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    idle(16, 1);

    phase = "cancel";
    cyc(1, 1, 0, 1, 0);
    idle(4, 1);

    phase = "saturate";
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0);
    idle(3, 0);
    @(negedge clk);
    up_rises = 0;
    @(posedge clk); #1;
    idle(36, 1);
    @(negedge clk);
    checks++;
    if (up_rises != 7) begin
      errors++;
      $display("FAIL saturate_pulse_count: got %0d step_up pulses want 7", up_rises);
    end
    @(posedge clk); #1;

    phase = "wrap";
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    idle(7, 1);
    cyc(1, 0, 0, 1, 0);
    idle(7, 1);

    phase = "clear_mid_pulse";
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    idle(12, 1);

    phase = "random";
    run = 1;
    for (int i = 0; i < 800; i++) begin
      bit u, d, c, r, rs;
      u  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 19) == 0) ? ~run : run;
      rs = ($urandom_range(0, 149) == 0);
      cyc(u, d, c, r, rs);
    end
    idle(20, 1);

    phase = "drain";
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected samples left unchecked, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
